// File: rtl/ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// ps2_key_receiver
//
// Receives scan codes from a PS/2 keyboard (device-to-host only). The raw
// PS/2 clock and data lines are synchronized, the clock is glitch-filtered,
// and each 11-bit frame (start, 8 data LSB first, odd parity, stop) is framed
// and checked. E0 / F0 prefixes are folded into the extended / break flags of
// the following code. Decoded one-cycle pulses are provided for the space bar
// (o_start) and the main-row digit keys (o_digit_valid / o_digit).
//
// Ports:
//   i_clk          system clock (only clock)
//   i_rst_n        synchronous active-low reset
//   i_ps2_clk      raw PS/2 clock, asynchronous
//   i_ps2_dat      raw PS/2 data, asynchronous
//   o_valid        1-cycle pulse: complete non-prefix code received
//   o_code         last received code, held until next o_valid
//   o_break        F0 prefix preceded o_code, held with o_code
//   o_extended     E0 prefix preceded o_code, held with o_code
//   o_err          1-cycle pulse: parity error, stop-bit error or timeout
//   o_start        1-cycle pulse: space bar pressed (not extended, not break)
//   o_digit_valid  1-cycle pulse: main-row digit key pressed
//   o_digit        value 0-9 of the last digit key press, held
// ---------------------------------------------------------------------------
module ps2_key_receiver #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_valid,
   output logic [7:0] o_code,
   output logic       o_break,
   output logic       o_extended,
   output logic       o_err,
   output logic       o_start,
   output logic       o_digit_valid,
   output logic [3:0] o_digit
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   // Odd parity over data plus parity bit: the XOR of all nine bits is 1.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return (^data) ^ par;
   endfunction

   // Main-row digit scan-code map: returns {hit, value}.
   function automatic logic [4:0] digit_map(input logic [7:0] code);
      case (code)
         8'h45:   return {1'b1, 4'd0};
         8'h16:   return {1'b1, 4'd1};
         8'h1E:   return {1'b1, 4'd2};
         8'h26:   return {1'b1, 4'd3};
         8'h25:   return {1'b1, 4'd4};
         8'h2E:   return {1'b1, 4'd5};
         8'h36:   return {1'b1, 4'd6};
         8'h3D:   return {1'b1, 4'd7};
         8'h3E:   return {1'b1, 4'd8};
         8'h46:   return {1'b1, 4'd9};
         default: return {1'b0, 4'd0};
      endcase
   endfunction

   // Synchronizers and clock filter
   logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic           filt_clk_q, filt_clk_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           edge_s;

   // Receiver state
   state_e         state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           parity_q, parity_d;
   logic           ext_pend_q, ext_pend_d;
   logic           brk_pend_q, brk_pend_d;
   logic [TCW-1:0] tmo_q, tmo_d;

   // Registered outputs
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic           start_q, start_d;
   logic           dvalid_q, dvalid_d;
   logic [7:0]     code_q, code_d;
   logic           break_q, break_d;
   logic           extended_q, extended_d;
   logic [3:0]     digit_q, digit_d;
   logic [4:0]     digit_hit_s;

   assign digit_hit_s = digit_map(shift_q);

   // Two-flop synchronizers for the raw PS/2 lines (idle level is high)
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= i_ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= i_ps2_dat;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Clock filter: toggle only after FILTER_LEN consecutive disagreeing samples
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      edge_s     = 1'b0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_clk_d = ~filt_clk_q;
            filt_cnt_d = '0;
            // Only a high-to-low transition of the filtered clock is an edge.
            edge_s     = filt_clk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FCW'(1);
         end
      end else begin
         filt_cnt_d = '0;
      end
   end

   // Filter state registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         filt_clk_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // Frame FSM, timeout, prefix folding and decode
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      tmo_d      = tmo_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      start_d    = 1'b0;
      dvalid_d   = 1'b0;
      code_d     = code_q;
      break_d    = break_q;
      extended_d = extended_q;
      digit_d    = digit_q;

      if (edge_s) begin
         // An accepted edge always wins over a coincident timeout.
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d   = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            ST_PARITY: begin
               parity_d = dat_s2_q;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (dat_s2_q && odd_parity_ok(shift_q, parity_q)) begin
                  if (shift_q == 8'hE0) begin
                     ext_pend_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_pend_d = 1'b1;
                  end else begin
                     valid_d    = 1'b1;
                     code_d     = shift_q;
                     break_d    = brk_pend_q;
                     extended_d = ext_pend_q;
                     ext_pend_d = 1'b0;
                     brk_pend_d = 1'b0;
                     if (!brk_pend_q && !ext_pend_q) begin
                        start_d  = (shift_q == 8'h29);
                        dvalid_d = digit_hit_s[4];
                        if (digit_hit_s[4]) begin
                           digit_d = digit_hit_s[3:0];
                        end else begin
                           digit_d = digit_q;
                        end
                     end else begin
                        start_d  = 1'b0;
                        dvalid_d = 1'b0;
                     end
                  end
               end else begin
                  err_d      = 1'b1;
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            state_d    = ST_IDLE;
            tmo_d      = '0;
         end else begin
            tmo_d = tmo_q + TCW'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   // Receiver and output registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         parity_q   <= 1'b0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         tmo_q      <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         dvalid_q   <= 1'b0;
         code_q     <= 8'h00;
         break_q    <= 1'b0;
         extended_q <= 1'b0;
         digit_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         tmo_q      <= tmo_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         start_q    <= start_d;
         dvalid_q   <= dvalid_d;
         code_q     <= code_d;
         break_q    <= break_d;
         extended_q <= extended_d;
         digit_q    <= digit_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_code        = code_q;
   assign o_break       = break_q;
   assign o_extended    = extended_q;
   assign o_err         = err_q;
   assign o_start       = start_q;
   assign o_digit_valid = dvalid_q;
   assign o_digit       = digit_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;

   localparam int FILTER_LEN = 8;
   localparam int TMO        = 1000;
   localparam int HALF       = 20;

   typedef struct packed {
      logic       valid;
      logic       err;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic       start;
      logic       dval;
      logic [3:0] digit;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       o_valid, o_break, o_extended, o_err, o_start, o_digit_valid;
   logic [7:0] o_code;
   logic [3:0] o_digit;

   int checks = 0;
   int errors = 0;

   ev_t sb[$];

   // Reference model state
   logic       m_pext = 1'b0, m_pbrk = 1'b0;
   logic [7:0] m_code = 8'h00;
   logic       m_brk = 1'b0, m_ext = 1'b0;
   logic [3:0] m_digit = 4'd0;

   ps2_key_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
      .o_valid(o_valid), .o_code(o_code), .o_break(o_break), .o_extended(o_extended),
      .o_err(o_err), .o_start(o_start), .o_digit_valid(o_digit_valid), .o_digit(o_digit)
   );

   always #5 clk = ~clk;

   // Monitor: pops the scoreboard on every o_valid / o_err pulse.
   always @(negedge clk) begin
      ev_t obs, exp_e;
      obs = {o_valid, o_err, o_code, o_break, o_extended, o_start, o_digit_valid, o_digit};
      if (o_valid || o_err) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h, scoreboard empty", obs);
         end else begin
            exp_e = sb.pop_front();
            if (obs !== exp_e) begin
               errors++;
               $display("FAIL event: got v=%b e=%b code=%h brk=%b ext=%b st=%b dv=%b dig=%0d, want v=%b e=%b code=%h brk=%b ext=%b st=%b dv=%b dig=%0d",
                        obs.valid, obs.err, obs.code, obs.brk, obs.ext, obs.start, obs.dval, obs.digit,
                        exp_e.valid, exp_e.err, exp_e.code, exp_e.brk, exp_e.ext, exp_e.start, exp_e.dval, exp_e.digit);
            end
         end
      end else if (o_start || o_digit_valid) begin
         checks++;
         errors++;
         $display("FAIL stray_pulse: start=%b digit_valid=%b without o_valid", o_start, o_digit_valid);
      end
   end

   function automatic logic [4:0] ref_digit(input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      case (b)
         8'h45: r = {1'b1, 4'd0};
         8'h16: r = {1'b1, 4'd1};
         8'h1E: r = {1'b1, 4'd2};
         8'h26: r = {1'b1, 4'd3};
         8'h25: r = {1'b1, 4'd4};
         8'h2E: r = {1'b1, 4'd5};
         8'h36: r = {1'b1, 4'd6};
         8'h3D: r = {1'b1, 4'd7};
         8'h3E: r = {1'b1, 4'd8};
         8'h46: r = {1'b1, 4'd9};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      logic [4:0] d;
      logic plain;
      if (b == 8'hE0) m_pext = 1'b1;
      else if (b == 8'hF0) m_pbrk = 1'b1;
      else begin
         m_code = b; m_brk = m_pbrk; m_ext = m_pext;
         plain = !m_pbrk && !m_pext;
         d = ref_digit(b);
         if (plain && d[4]) m_digit = d[3:0];
         e = {1'b1, 1'b0, m_code, m_brk, m_ext, plain && (b == 8'h29), plain && d[4], m_digit};
         sb.push_back(e);
         m_pbrk = 1'b0; m_pext = 1'b0;
      end
   endtask

   task automatic model_err();
      m_pbrk = 1'b0; m_pext = 1'b0;
      sb.push_back({1'b0, 1'b1, m_code, m_brk, m_ext, 1'b0, 1'b0, m_digit});
   endtask

   task automatic model_reset();
      m_pbrk = 1'b0; m_pext = 1'b0; m_code = 8'h00;
      m_brk = 1'b0; m_ext = 1'b0; m_digit = 4'd0;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_dat = b;
      repeat (HALF / 2) @(negedge clk);
      if (glitch) begin
         ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_at);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
      ps2_dat = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b);
      model_byte(b);
      send_bits(b, 1'b0, 11, -1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d expected events never seen, want 0", name, sb.size());
         sb.delete();
      end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_valid, o_err, o_code, o_break, o_extended, o_start, o_digit_valid, o_digit} !== 18'd0) begin
         errors++;
         $display("FAIL reset_outputs: got code=%h digit=%0d v=%b e=%b, want all zero", o_code, o_digit, o_valid, o_err);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_space();
      send_frame(8'h29);
      wait_drain("space");
   endtask

   task automatic test_break();
      send_frame(8'hF0);
      send_frame(8'h29);
      wait_drain("break");
   endtask

   task automatic test_extended();
      send_frame(8'hE0);
      send_frame(8'h75);
      send_frame(8'h3E);
      wait_drain("extended");
      checks++;
      if (o_digit !== 4'd8 || o_extended !== 1'b0) begin
         errors++;
         $display("FAIL extended_hold: got digit=%0d ext=%b, want digit=8 ext=0", o_digit, o_extended);
      end
   endtask

   task automatic test_parity_err();
      model_err();
      send_bits(8'h16, 1'b1, 11, -1);
      send_frame(8'h16);
      wait_drain("parity");
      checks++;
      if (o_digit !== 4'd1) begin
         errors++;
         $display("FAIL parity_recover: got digit=%0d, want 1", o_digit);
      end
   endtask

   task automatic test_timeout();
      model_err();
      send_bits(8'h45, 1'b0, 5, -1);
      repeat (TMO + 100) @(negedge clk);
      send_frame(8'h45);
      wait_drain("timeout");
      checks++;
      if (o_digit !== 4'd0 || o_code !== 8'h45) begin
         errors++;
         $display("FAIL timeout_recover: got digit=%0d code=%h, want digit=0 code=45", o_digit, o_code);
      end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h3D);
      wait_drain("pre_reset");
      send_bits(8'h29, 1'b0, 5, -1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (o_code !== 8'h00 || o_digit !== 4'd0) begin
         errors++;
         $display("FAIL midreset_clear: got code=%h digit=%0d, want 00 and 0", o_code, o_digit);
      end
      repeat (10) @(negedge clk);
      send_frame(8'h29);
      wait_drain("midreset");
   endtask

   task automatic test_glitch();
      model_byte(8'h1E);
      send_bits(8'h1E, 1'b0, 11, 4);
      wait_drain("glitch");
      checks++;
      if (o_digit !== 4'd2) begin
         errors++;
         $display("FAIL glitch_digit: got digit=%0d, want 2", o_digit);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h45);
      send_frame(8'h16);
      send_frame(8'hF0);
      send_frame(8'h16);
      send_frame(8'h46);
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h5A);
      wait_drain("b2b");
      checks++;
      if (o_code !== 8'h5A || o_break !== 1'b1 || o_extended !== 1'b1 || o_digit !== 4'd9) begin
         errors++;
         $display("FAIL b2b_hold: got code=%h brk=%b ext=%b digit=%0d, want 5a 1 1 9",
                  o_code, o_break, o_extended, o_digit);
      end
   endtask

   initial begin
      test_reset();
      test_space();
      test_break();
      test_extended();
      test_parity_err();
      test_timeout();
      test_reset_midframe();
      test_glitch();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Receives scan codes from a PS/2 keyboard on the DE2-115 PS2_CLK/PS2_DAT pins. It frames and checks each byte, folds E0/F0 prefixes into flags, and emits one-cycle event pulses. It sits in the input path beside the KEY debouncer. Its o_start pulse can drive the random generator's start input in place of a KEY[0] press, and o_digit/o_digit_valid give a numeric entry path in the opposite direction to the seven-segment display path.

## Interface
Parameters:
- FILTER_LEN, default 8: consecutive agreeing synchronized samples needed before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, default 50000: cycles without an accepted falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- i_clk, input, 1: system clock (CLOCK_50). This is the only clock.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_ps2_clk, input, 1: raw PS/2 clock, asynchronous to i_clk.
- i_ps2_dat, input, 1: raw PS/2 data, asynchronous to i_clk.
- o_valid, output, 1: one-cycle pulse when a complete non-prefix code is received.
- o_code, output, 8: received code. Held until the next o_valid.
- o_break, output, 1: a key-release (F0) prefix preceded o_code. Held with o_code.
- o_extended, output, 1: an E0 prefix preceded o_code. Held with o_code.
- o_err, output, 1: one-cycle pulse on parity error, stop-bit error or timeout.
- o_start, output, 1: one-cycle pulse when the space bar (0x29) is pressed, not extended and not break.
- o_digit_valid, output, 1: one-cycle pulse when a main-row digit key is pressed.
- o_digit, output, 4: value 0-9 of the last digit key press. Held.

## Operation
- Input conditioning: 2-flop synchronizer on both raw inputs. A clock filter counts consecutive samples that differ from the filtered level. When the count reaches FILTER_LEN, the filtered level toggles. A falling edge of the filtered clock is an accepted edge, and i_ps2_dat (synchronized) is sampled in that same cycle.
- Frame format: 11 bits, in order start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM:
  - IDLE: on an accepted edge with data=0, go to DATA with bit count 0. With data=1, stay in IDLE silently (treated as a glitch).
  - DATA: shift the sample into shift[7] with a right shift on each edge. After the 8th bit, go to PARITY.
  - PARITY: store the sample, then go to STOP.
  - STOP: on the edge, check that stop=1 and that the XOR of the 8 data bits and the parity bit is 1. On pass, process the byte. On fail, pulse o_err, clear both prefix flags and go to IDLE. In either case return to IDLE.
- Byte processing:
  - 0xE0 sets ext_pending. 0xF0 sets brk_pending. Neither produces o_valid.
  - Any other byte: o_valid=1, o_code=byte, o_break=brk_pending, o_extended=ext_pending. Both pending flags are cleared in the same cycle.
- Decode, qualified by o_valid, break=0 and extended=0:
  - o_start is asserted when code=0x29.
  - Digit map: 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9. A match pulses o_digit_valid and updates o_digit.
- Timeout: the counter clears on every accepted edge and counts while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES-1, the block pulses o_err, clears the pending flags, returns to IDLE and clears the counter. If a timeout and an accepted edge fall in the same cycle, the edge wins and the counter clears.
- The receiver never drives the PS/2 lines. Host-to-device commands are out of scope.

## Timing
- Reset, synchronous: FSM to IDLE; synchronizers and filtered clock to 1; all counters, shift register and flags to 0. All outputs read 0, including o_code=0x00 and o_digit=0. A reset mid-frame discards the partial frame without o_err.
- Latency from a raw PS/2 falling edge to the accepted edge: 2 synchronizer cycles plus FILTER_LEN cycles.
- o_valid, o_start, o_digit_valid and o_err are registered. They assert on the cycle after the accepted stop-bit edge, for exactly one cycle.
- o_code, o_break, o_extended and o_digit update on the same cycle o_valid asserts, and are stable until the next o_valid.
- o_valid and o_err never assert in the same cycle.
- Back-to-back frames: processing finishes the cycle after STOP, so a start bit arriving at the next accepted edge is never missed.

## Test plan
- Frame 0x29 with parity 0 → o_valid for 1 cycle, o_code=0x29, o_break=0, o_extended=0, o_start=1, o_err=0.
- Frames F0, 29 → exactly one o_valid, with o_code=0x29, o_break=1, o_start=0. The F0 frame produces no pulse.
- Frames E0, 75 → o_code=0x75, o_extended=1. Then frame 3E → o_extended=0, o_digit_valid=1, o_digit=8.
- Frame 0x16 with parity bit flipped → o_err=1 for 1 cycle, o_valid=0. The next good 0x16 → o_digit=1.
- Send 5 bits, then idle high for TIMEOUT_CYCLES → o_err pulses once. A following good 0x45 → o_digit_valid, o_digit=0.
- Assert i_rst_n=0 for 1 cycle after bit 4 of a frame, then send a full 0x29 frame → no o_err, and one o_valid with o_code=0x29. Also verify a 2-cycle glitch on i_ps2_clk (shorter than FILTER_LEN) causes no bit shift.
